// File: rtl/fir_pkg.sv
// Shared sample types for FIR_filter and its downstream decimator.
package fir_pkg;
  localparam int DATA_W = 8;
  typedef logic signed [DATA_W-1:0] sample_t;
  typedef enum logic {ACCUM, DUMP} phase_state_e;
endpackage

// File: rtl/fir_decimator_if.sv
// Sample-in / decimated-out bus of fir_decimator; master drives samples and accepts results.
interface fir_decimator_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  logic                         in_valid;
  logic signed [DATA_W-1:0]     fir_yn;
  logic                         flush;
  logic signed [DATA_W-1:0]     dec_out;
  logic                         out_valid;
  logic                         out_ready;
  logic [$clog2(DEPTH+1)-1:0]   fill;
  logic                         overflow;

  modport master (
    output in_valid, fir_yn, flush, out_ready,
    input  dec_out, out_valid, fill, overflow
  );
  modport slave (
    input  in_valid, fir_yn, flush, out_ready,
    output dec_out, out_valid, fill, overflow
  );
endinterface

// File: rtl/fir_decimator_fifo.sv
// Small synchronous FIFO with occupancy count; a push while full succeeds only alongside a pop.
// Head data reads as zero while empty.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        push,
  input  logic [W-1:0]                push_dat,
  input  logic                        pop,
  output logic [W-1:0]                head_dat,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic                        full,
  output logic                        empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign count    = count_q;
  assign head_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (clr) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= push_dat;
  end
endmodule

// File: rtl/fir_decimator.sv
// Accumulate-and-dump decimator behind FIR_filter: averages DECIM valid samples per result
// and queues results in an output FIFO with valid/ready; results arriving at a full FIFO are dropped.
module fir_decimator
  import fir_pkg::*;
#(
  parameter int DATA_W = fir_pkg::DATA_W,
  parameter int DECIM  = 4,
  parameter int DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  fir_decimator_if.slave   bus
);
  localparam int LOG2D = $clog2(DECIM);
  localparam int ACC_W = DATA_W + LOG2D;

  phase_state_e             state_q, state_d;
  logic [LOG2D-1:0]         phase_q, phase_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  sum;
  logic [DATA_W-1:0]        result;
  logic                     push;
  logic                     pop;
  logic                     full;
  logic                     empty;
  logic                     overflow_q;

  assign sum    = acc_q + {{LOG2D{bus.fir_yn[DATA_W-1]}}, bus.fir_yn};
  // Taking the upper DATA_W bits is the arithmetic shift by LOG2D (floor) with no further truncation.
  assign result = sum[ACC_W-1:LOG2D];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      phase_q <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    acc_d   = acc_q;
    push    = 1'b0;
    if (bus.flush) begin
      state_d = ACCUM;
      phase_d = '0;
      acc_d   = '0;
    end else if (bus.in_valid) begin
      case (state_q)
        ACCUM: begin
          acc_d   = sum;
          phase_d = phase_q + LOG2D'(1);
          state_d = (phase_q == LOG2D'(DECIM-2)) ? DUMP : ACCUM;
        end
        DUMP: begin
          push    = 1'b1;
          acc_d   = '0;
          phase_d = '0;
          state_d = ACCUM;
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  assign pop = ~empty & bus.out_ready;

  sync_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (bus.flush),
    .push     (push),
    .push_dat (result),
    .pop      (pop),
    .head_dat (bus.dec_out),
    .count    (bus.fill),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    overflow_q <= 1'b0;
    else if (bus.flush)            overflow_q <= 1'b0;
    else if (push && full && !pop) overflow_q <= 1'b1;
  end

  assign bus.out_valid = ~empty;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_fir_decimator.sv
// Directed bench for fir_decimator with DECIM=4, DEPTH=4, DATA_W=8.
module tb_fir_decimator;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fir_decimator_if #(.DATA_W(8), .DEPTH(4)) bus ();
  fir_decimator #(.DATA_W(8), .DECIM(4), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0][7:0] s;
    logic [7:0]      exp;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic rdy, input logic fl);
    bus.in_valid  = v;
    bus.fir_yn    = d;
    bus.out_ready = rdy;
    bus.flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.fir_yn    = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_valid", {7'd0, bus.out_valid}, 8'h00);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_valid", {7'd0, bus.out_valid}, 8'h00);
    chk("rst_fill", {5'd0, bus.fill}, 8'h00);
    chk("rst_ovf", {7'd0, bus.overflow}, 8'h00);
    chk("rst_dout", bus.dec_out, 8'h00);

    vecs[0] = '{s: {8'h10, 8'h0C, 8'h08, 8'h04}, exp: 8'h0A};
    vecs[1] = '{s: {8'hFF, 8'hFF, 8'hFF, 8'hFF}, exp: 8'hFF};
    vecs[2] = '{s: {8'hFF, 8'hFF, 8'hFF, 8'hFE}, exp: 8'hFE};
    vecs[3] = '{s: {8'h7F, 8'h7F, 8'h7F, 8'h7F}, exp: 8'h7F};
    vecs[4] = '{s: {8'h80, 8'h80, 8'h80, 8'h80}, exp: 8'h80};
    vecs[5] = '{s: {8'h00, 8'h00, 8'h00, 8'hFD}, exp: 8'hFF};

    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 4; j++) begin
        cyc(1'b1, vecs[i].s[j], 1'b1, 1'b0);
        if (j == 2) chk("vec_early_valid", {7'd0, bus.out_valid}, 8'h00);
      end
      chk("vec_valid", {7'd0, bus.out_valid}, 8'h01);
      chk("vec_dout", bus.dec_out, vecs[i].exp);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("vec_valid_drop", {7'd0, bus.out_valid}, 8'h00);
    end

    // Gaps in in_valid must not advance the phase.
    cyc(1'b1, 8'h01, 1'b1, 1'b0);
    cyc(1'b0, 8'h55, 1'b1, 1'b0);
    cyc(1'b1, 8'h02, 1'b1, 1'b0);
    cyc(1'b0, 8'h55, 1'b1, 1'b0);
    cyc(1'b0, 8'h55, 1'b1, 1'b0);
    chk("gap_no_valid", {7'd0, bus.out_valid}, 8'h00);
    cyc(1'b1, 8'h03, 1'b1, 1'b0);
    chk("gap_no_valid2", {7'd0, bus.out_valid}, 8'h00);
    cyc(1'b1, 8'h04, 1'b1, 1'b0);
    chk("gap_valid", {7'd0, bus.out_valid}, 8'h01);
    chk("gap_dout", bus.dec_out, 8'h02);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Backpressure: five results into a four-entry FIFO.
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, 8'h01, 1'b0, 1'b0);
      if (k == 15) begin
        chk("bp_fill_at_full", {5'd0, bus.fill}, 8'h04);
        chk("bp_ovf_at_full", {7'd0, bus.overflow}, 8'h00);
      end
    end
    chk("bp_fill", {5'd0, bus.fill}, 8'h04);
    chk("bp_ovf", {7'd0, bus.overflow}, 8'h01);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("bp_stable_valid", {7'd0, bus.out_valid}, 8'h01);
    chk("bp_stable_dout", bus.dec_out, 8'h01);
    for (int k = 0; k < 4; k++) begin
      chk("bp_drain_valid", {7'd0, bus.out_valid}, 8'h01);
      chk("bp_drain_dout", bus.dec_out, 8'h01);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("bp_empty", {7'd0, bus.out_valid}, 8'h00);
    chk("bp_fill0", {5'd0, bus.fill}, 8'h00);
    chk("bp_ovf_sticky", {7'd0, bus.overflow}, 8'h01);

    // Flush mid-group, with a sample presented in the flush cycle.
    for (int k = 0; k < 4; k++) cyc(1'b1, 8'h20, 1'b0, 1'b0);
    chk("fl_pre_fill", {5'd0, bus.fill}, 8'h01);
    cyc(1'b1, 8'h40, 1'b0, 1'b0);
    cyc(1'b1, 8'h40, 1'b0, 1'b0);
    cyc(1'b1, 8'h40, 1'b0, 1'b1);
    chk("fl_fill", {5'd0, bus.fill}, 8'h00);
    chk("fl_ovf", {7'd0, bus.overflow}, 8'h00);
    chk("fl_valid", {7'd0, bus.out_valid}, 8'h00);
    for (int k = 0; k < 4; k++) cyc(1'b1, 8'h10, 1'b1, 1'b0);
    chk("fl_after_dout", bus.dec_out, 8'h10);
    chk("fl_after_fill", {5'd0, bus.fill}, 8'h01);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Full FIFO with push and pop in the same cycle.
    for (int g = 1; g <= 4; g++)
      for (int k = 0; k < 4; k++) cyc(1'b1, 8'(g), 1'b0, 1'b0);
    chk("pp_fill_full", {5'd0, bus.fill}, 8'h04);
    chk("pp_head", bus.dec_out, 8'h01);
    for (int k = 0; k < 3; k++) cyc(1'b1, 8'h05, 1'b0, 1'b0);
    cyc(1'b1, 8'h05, 1'b1, 1'b0);
    chk("pp_fill", {5'd0, bus.fill}, 8'h04);
    chk("pp_ovf", {7'd0, bus.overflow}, 8'h00);
    for (int g = 2; g <= 5; g++) begin
      chk("pp_order", bus.dec_out, 8'(g));
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("pp_empty", {7'd0, bus.out_valid}, 8'h00);

    // Asynchronous reset mid-group.
    for (int k = 0; k < 4; k++) cyc(1'b1, 8'h20, 1'b0, 1'b0);
    cyc(1'b1, 8'h40, 1'b0, 1'b0);
    cyc(1'b1, 8'h40, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_fill", {5'd0, bus.fill}, 8'h00);
    chk("ar_valid", {7'd0, bus.out_valid}, 8'h00);
    chk("ar_dout", bus.dec_out, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) cyc(1'b1, 8'h10, 1'b1, 1'b0);
    chk("ar_after_valid", {7'd0, bus.out_valid}, 8'h01);
    chk("ar_after_dout", bus.dec_out, 8'h10);
    chk("ar_after_fill", {5'd0, bus.fill}, 8'h01);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
